// File: rtl/rv_alu_pkg.sv
// Shared RV32I ALU issue definitions: function codes, opcodes and the issued-op payload.
package rv_alu_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_fun_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    alu_fun_t             alu_fun;
    logic [RV_XLEN-1:0]   src_a;
    logic [RV_XLEN-1:0]   src_b;
    logic [4:0]           rd_addr;
    logic                 rd_we;
    logic                 illegal;
  } issue_op_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: a registered output stage plus one overflow slot, so the
// upstream ready depends only on local state and no op is dropped or duplicated.
module skid_buffer #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  generate
    if (DEPTH != 2) begin : g_depth_check
      $error("skid_buffer: only DEPTH=2 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  skid_state_t state, next_state;
  T            out_q, skid_q;
  logic        in_xfer, out_xfer;
  logic        load_out, load_skid, move_skid;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = out_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Next occupancy and which register captures data this cycle.
  always_comb begin
    next_state = state;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          next_state = ONE;
          load_out   = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_out = 1'b1;
        end else if (in_xfer) begin
          next_state = TWO;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          next_state = ONE;
          move_skid  = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Occupancy state and payload registers; reset discards everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state <= next_state;
      if (load_out) begin
        out_q <= in_data;
      end else if (move_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage for OP, OP-IMM, LUI and AUIPC feeding the ALU through a
// 2-entry skid buffer. Optional macro ALU_ISSUE_STATS_EN adds issued/illegal counters.
module alu_issue_stage
  import rv_alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_fun,
  output logic [XLEN-1:0] src_a,
  output logic [XLEN-1:0] src_b,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]     issued_cnt,
  output logic [31:0]     illegal_cnt
`endif
);

  generate
    if (XLEN != RV_XLEN) begin : g_xlen_check
      $error("alu_issue_stage: XLEN must match rv_alu_pkg::RV_XLEN");
    end
  endgenerate

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] u_imm;
  logic            legal;
  issue_op_t       dec_op;
  issue_op_t       out_op;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign i_imm  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign u_imm  = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};

  // Decode the instruction into an issue op; anything undecodable becomes a zeroed illegal op.
  always_comb begin
    dec_op         = '0;
    legal          = 1'b0;
    dec_op.rd_addr = instr[11:7];
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_op.alu_fun = alu_fun_t'({instr[30], funct3});
        dec_op.src_a   = rs1_data;
        dec_op.src_b   = rs2_data;
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
        dec_op.alu_fun = alu_fun_t'({(funct3 == 3'b101) ? instr[30] : 1'b0, funct3});
        dec_op.src_a   = rs1_data;
        dec_op.src_b   = i_imm;
      end
      OPC_LUI: begin
        legal          = 1'b1;
        dec_op.alu_fun = ALU_LUI;
        dec_op.src_a   = u_imm;
        dec_op.src_b   = '0;
      end
      OPC_AUIPC: begin
        legal          = 1'b1;
        dec_op.alu_fun = ALU_ADD;
        dec_op.src_a   = pc;
        dec_op.src_b   = u_imm;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec_op.alu_fun = ALU_ADD;
      dec_op.src_a   = '0;
      dec_op.src_b   = '0;
    end
    dec_op.rd_we   = legal && (instr[11:7] != 5'd0);
    dec_op.illegal = !legal;
  end

  skid_buffer #(
    .T     (issue_op_t),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_op)
  );

  assign alu_fun = out_op.alu_fun;
  assign src_a   = out_op.src_a;
  assign src_b   = out_op.src_b;
  assign rd_addr = out_op.rd_addr;
  assign rd_we   = out_op.rd_we;
  assign illegal = out_op.illegal;

`ifdef ALU_ISSUE_STATS_EN
  // Count every op handed to the ALU, and separately those flagged illegal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else if (out_valid && out_ready) begin
      issued_cnt <= issued_cnt + 32'd1;
      if (out_op.illegal) begin
        illegal_cnt <= illegal_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_fun;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issued_cnt;
  logic [31:0] illegal_cnt;
  int          model_issued;
  int          model_illegal;
`endif

  int checks = 0;
  int errors = 0;
  logic [74:0] model_q[$];

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_fun   (alu_fun),
    .src_a     (src_a),
    .src_b     (src_b),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .illegal   (illegal)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .issued_cnt  (issued_cnt),
    .illegal_cnt (illegal_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference decode from the instruction-set rules: {fun, src_a, src_b, rd, rd_we, illegal}.
  function automatic logic [74:0] refOp(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] a, input logic [31:0] b);
    int          op, f3, f7;
    bit          ok;
    logic [3:0]  fun;
    logic [31:0] sa, sb, iimm, uimm;
    logic [4:0]  rd;
    op   = int'(ins[6:0]);
    f3   = int'(ins[14:12]);
    f7   = int'(ins[31:25]);
    iimm = {{20{ins[31]}}, ins[31:20]};
    uimm = ins & 32'hFFFF_F000;
    rd   = ins[11:7];
    ok = 0; fun = 4'd0; sa = 32'd0; sb = 32'd0;
    if (op == 'h33) begin
      ok  = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      fun = 4'(f3 + (ins[30] ? 8 : 0));
      sa  = a;
      sb  = b;
    end else if (op == 'h13) begin
      ok  = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 32);
      fun = 4'((f3 == 5 && ins[30]) ? f3 + 8 : f3);
      sa  = a;
      sb  = iimm;
    end else if (op == 'h37) begin
      ok = 1; fun = 4'd9; sa = uimm; sb = 32'd0;
    end else if (op == 'h17) begin
      ok = 1; fun = 4'd0; sa = pcv; sb = uimm;
    end
    if (!ok) begin
      fun = 4'd0; sa = 32'd0; sb = 32'd0;
    end
    return {fun, sa, sb, rd, (ok && rd != 5'd0), !ok};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] ins;
    int          kind, f7sel;
    ins   = $urandom;
    kind  = $urandom_range(0, 5);
    f7sel = $urandom_range(0, 3);
    case (kind)
      0:       ins[6:0] = 7'b0110011;
      1, 4:    ins[6:0] = 7'b0010011;
      2:       ins[6:0] = 7'b0110111;
      3:       ins[6:0] = 7'b0010111;
      default: ;
    endcase
    if (kind == 0 || kind == 1 || kind == 4) begin
      if (f7sel < 2) ins[31:25] = 7'b0000000;
      else if (f7sel == 2) ins[31:25] = 7'b0100000;
    end
    if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
    return ins;
  endfunction

  task automatic checkModel();
    checkOutput("out_valid", out_valid, model_q.size() > 0);
    checkOutput("in_ready", in_ready, model_q.size() < 2);
    if (model_q.size() > 0)
      checkOutput("op", {alu_fun, src_a, src_b, rd_addr, rd_we, illegal}, model_q[0]);
`ifdef ALU_ISSUE_STATS_EN
    checkOutput("issued_cnt", issued_cnt, model_issued);
    checkOutput("illegal_cnt", illegal_cnt, model_illegal);
`endif
  endtask

  // Drive one cycle of inputs at the negedge, advance the model, then check after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                               input logic [31:0] a, input logic [31:0] b, input logic ordy);
    bit in_x, out_x;
    in_valid  = v;
    instr     = ins;
    pc        = pcv;
    rs1_data  = a;
    rs2_data  = b;
    out_ready = ordy;
    in_x  = v && (model_q.size() < 2);
    out_x = (model_q.size() > 0) && ordy;
    if (out_x) begin
`ifdef ALU_ISSUE_STATS_EN
      model_issued++;
      if (model_q[0][0]) model_illegal++;
`endif
      void'(model_q.pop_front());
    end
    if (in_x) model_q.push_back(refOp(ins, pcv, a, b));
    @(posedge clk);
    @(negedge clk);
    checkModel();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; pc = 32'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; out_ready = 1'b0;
`ifdef ALU_ISSUE_STATS_EN
    model_issued = 0; model_illegal = 0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_fields", {alu_fun, src_a, src_b, rd_addr, rd_we, illegal}, 75'd0);
    rst_n = 1'b1;

    applyStimulus(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1);
    checkOutput("add", {out_valid, alu_fun, src_a, src_b, rd_addr, rd_we, illegal},
                {1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0});
    applyStimulus(1, 32'h402081B3, 32'h0, 32'd9, 32'd4, 1);
    checkOutput("sub_fun", alu_fun, 4'b1000);
    applyStimulus(1, 32'h40435293, 32'h0, 32'h80, 32'd0, 1);
    checkOutput("srai", {alu_fun, src_b[4:0], rd_addr}, {4'b1101, 5'd4, 5'd5});
    applyStimulus(1, 32'h123450B7, 32'h0, 32'd1, 32'd2, 1);
    checkOutput("lui", {alu_fun, src_a, src_b}, {4'b1001, 32'h12345000, 32'd0});
    applyStimulus(1, 32'h00001117, 32'h100, 32'd1, 32'd2, 1);
    checkOutput("auipc", {alu_fun, src_a, src_b}, {4'b0000, 32'h100, 32'h1000});
    applyStimulus(1, 32'h00000073, 32'h0, 32'd3, 32'd3, 1);
    checkOutput("ecall", {illegal, rd_we, alu_fun}, {1'b1, 1'b0, 4'b0000});
    applyStimulus(1, 32'h00100013, 32'h0, 32'd0, 32'd0, 1);
    checkOutput("addi_x0", {illegal, rd_we, src_b}, {1'b0, 1'b0, 32'd1});

    applyStimulus(1, 32'h002081B3, 32'h0, 32'd11, 32'd12, 0);
    applyStimulus(1, 32'h402081B3, 32'h0, 32'd21, 32'd22, 0);
    checkOutput("bp_in_ready", in_ready, 1'b0);
    applyStimulus(1, 32'h123450B7, 32'h0, 32'd0, 32'd0, 0);
    applyStimulus(1, 32'h123450B7, 32'h0, 32'd0, 32'd0, 1);
    applyStimulus(1, 32'h123450B7, 32'h0, 32'd0, 32'd0, 1);
    applyStimulus(0, 32'h0, 32'h0, 32'd0, 32'd0, 1);
    applyStimulus(0, 32'h0, 32'h0, 32'd0, 32'd0, 1);

    applyStimulus(1, 32'h00000073, 32'h0, 32'd1, 32'd1, 0);
    applyStimulus(1, 32'h002081B3, 32'h0, 32'd1, 32'd1, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_two_out_valid", out_valid, 1'b0);
    checkOutput("rst_two_in_ready", in_ready, 1'b1);
`ifdef ALU_ISSUE_STATS_EN
    checkOutput("rst_two_cnts", {issued_cnt, illegal_cnt}, 64'd0);
    model_issued = 0; model_illegal = 0;
`endif
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom, $urandom, $urandom,
                    (i >= 200 && i < 300) ? 1'b1 : ($urandom_range(0, 2) != 0));
    end
    repeat (3) applyStimulus(0, 32'h0, 32'h0, 32'd0, 32'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that produces the 4-bit ALU function code and both ALU operands from a fetched RV32I instruction.
- Covers OP, OP-IMM, LUI and AUIPC. Drives the ALU's alu_fun/srcA/srcB inputs through a registered valid/ready interface.
- Sits between fetch/register-file read and the ALU in the multicycle core. Includes a 2-entry skid buffer so back-pressure never drops or duplicates an instruction.

Parameters:
- XLEN, 32, datapath width for operands, pc and immediates
- DEPTH, 2, skid-buffer entries (only 2 is supported; the value is checked at elaboration)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instr/pc/rs1_data/rs2_data are valid
- in_ready  out  1  stage can accept this cycle
- instr  in  32  RV32I instruction word
- pc  in  XLEN  address of instr
- rs1_data  in  XLEN  register-file read of rs1
- rs2_data  in  XLEN  register-file read of rs2
- out_valid  out  1  issued op valid
- out_ready  in  1  ALU/writeback accepts op
- alu_fun  out  4  ALU function code
- src_a  out  XLEN  ALU srcA
- src_b  out  XLEN  ALU srcB
- rd_addr  out  5  destination register
- rd_we  out  1  register write enable
- illegal  out  1  instruction not decodable by this stage

Behaviour:
- Reset (async, rst_n=0): out_valid=0, in_ready=1, alu_fun=4'b0000, src_a=0, src_b=0, rd_addr=0, rd_we=0, illegal=0, skid buffer emptied. Reset mid-transfer discards all held ops.
- Handshake: an input transfer occurs when in_valid&&in_ready; an output transfer occurs when out_valid&&out_ready. Output fields are held stable while out_valid&&!out_ready.
- Latency: 1 cycle from input transfer to out_valid.
- Skid buffer states: EMPTY, ONE (output register full), TWO (output and skid both full).
  - in_ready = (state != TWO).
  - EMPTY + input transfer -> ONE.
  - ONE + input transfer without output transfer -> TWO.
  - ONE + output transfer without input transfer -> EMPTY.
  - ONE + simultaneous input and output transfer -> ONE, holding the new op.
  - TWO + output transfer -> ONE; the skid entry moves to the output register.
- Ordering: strict FIFO. Full-throughput streaming (one op per cycle) holds whenever out_ready stays high.
- Immediates: I-imm = sign-extended instr[31:20]; U-imm = {instr[31:12], 12'b0}.
- Decode by opcode (instr[6:0]):
  - OP 0110011:
    - alu_fun = {instr[30], funct3}, src_a = rs1_data, src_b = rs2_data.
    - Legal only if funct7 = 0000000, or funct7 = 0100000 with funct3 in {000, 101}.
  - OP-IMM 0010011:
    - src_a = rs1_data, src_b = I-imm.
    - alu_fun = {(funct3==101) ? instr[30] : 0, funct3}.
    - funct3=001 is legal only if instr[31:25]=0000000.
    - funct3=101 is legal only if instr[31:25] is 0000000 or 0100000.
  - LUI 0110111: alu_fun = 4'b1001, src_a = U-imm, src_b = 0.
  - AUIPC 0010111: alu_fun = 4'b0000, src_a = pc, src_b = U-imm.
- Function-code results of this decode: SUB = 1000, SRA/SRAI = 1101, SLT = 0010, SLTU = 0011. Codes 1010, 1011, 1100, 1110 and 1111 are never emitted.
- rd_addr = instr[11:7]. rd_we = 1 for legal ops with rd != 0; otherwise rd_we = 0.
- Illegal instruction (any other opcode or funct violation):
  - illegal = 1, alu_fun = 0000, src_a = 0, src_b = 0, rd_we = 0.
  - The op still consumes one handshake slot, so the stage never stalls on it.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- When defined:
  - Adds output ports issued_cnt[31:0] and illegal_cnt[31:0].
  - Each counter increments on every output transfer, and illegal_cnt only when illegal=1.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined: the ports and logic are absent, and the block's behaviour is otherwise identical.

Decomposition:
- Shared package rv_alu_pkg holds:
  - the alu_fun_t enum (ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, LUI 1001, SRA 1101)
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC
  - the issue_op_t struct {alu_fun, src_a, src_b, rd_addr, rd_we, illegal}
- Combinational decode lives in the top module.
- One sub-module, skid_buffer, generic over the issue_op_t payload.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7 -> next cycle alu_fun=0000, src_a=5, src_b=7, rd_addr=3, rd_we=1, illegal=0.
- sub (0x402081B3) then srai x5,x6,4 (0x40435293) back-to-back, out_ready=1 -> alu_fun=1000 then 1101 (src_b=4, rd_addr=5) on consecutive cycles.
- lui x1,0x12345 (0x123450B7) -> alu_fun=1001, src_a=0x12345000; auipc x2,1 (0x00001117) at pc=0x100 -> alu_fun=0000, src_a=0x100, src_b=0x1000.
- out_ready=0, send 3 ops -> in_ready drops after 2 accepted; raise out_ready -> ops emerge in order, none lost or duplicated.
- instr=0x00000073 (ECALL) -> illegal=1, rd_we=0, alu_fun=0000; addi x0,x0,1 -> illegal=0, rd_we=0.
- Assert rst_n low while state=TWO -> out_valid=0 and in_ready=1 immediately; with ALU_ISSUE_STATS_EN, both counters read 0.
